// File: rtl/demux_stream_1xn_if.sv
// Stream bundle for demux_stream_1xn: one input word with channel select, NCH output lanes.
// bcast exists only when DEMUX_BCAST_EN is defined.
interface demux_stream_1xn_if #(
    parameter int DW  = 8,
    parameter int NCH = 4
);
    localparam int SW = $clog2(NCH);

    logic [DW-1:0]     din;
    logic [SW-1:0]     A;
`ifdef DEMUX_BCAST_EN
    logic              bcast;
`endif
    logic              din_valid;
    logic              din_ready;
    logic [NCH*DW-1:0] Y;
    logic [NCH-1:0]    Y_valid;
    logic [NCH-1:0]    Y_ready;

`ifdef DEMUX_BCAST_EN
    modport master (output din, A, bcast, din_valid, Y_ready,
                    input  din_ready, Y, Y_valid);
    modport slave  (input  din, A, bcast, din_valid, Y_ready,
                    output din_ready, Y, Y_valid);
`else
    modport master (output din, A, din_valid, Y_ready,
                    input  din_ready, Y, Y_valid);
    modport slave  (input  din, A, din_valid, Y_ready,
                    output din_ready, Y, Y_valid);
`endif
endinterface

// File: rtl/demux_stream_1xn.sv
// 1:NCH stream demux with a one-entry register per channel; DEMUX_BCAST_EN adds broadcast to all lanes.
// Latency: 1 clock from accepting edge to Y_valid; out-of-range selects are dropped and counted.
// Backpressure: din_ready follows the selected lane (free or draining this cycle), forced low in reset.
module demux_stream_1xn #(
    parameter int DW  = 8,
    parameter int NCH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    demux_stream_1xn_if.slave  bus,
    output logic [7:0]         drop_cnt
);
    logic [NCH-1:0][DW-1:0] r_dat;
    logic [NCH-1:0]         r_vld;
    logic [7:0]             r_drop;

    logic [NCH-1:0]         w_free;
    logic [NCH-1:0]         w_hit;
    logic [NCH-1:0]         w_load;
    logic                   w_in_range;
    logic                   w_bcast;
    logic                   w_rdy;
    logic                   w_xfer;

`ifdef DEMUX_BCAST_EN
    assign w_bcast = bus.bcast;
`else
    assign w_bcast = 1'b0;
`endif

    // A lane can take a word if it is empty or its current word leaves this cycle.
    assign w_free     = ~r_vld | bus.Y_ready;
    assign w_in_range = 32'(bus.A) < NCH;

    always_comb begin
        w_hit = '0;
        for (int i = 0; i < NCH; i++) begin
            w_hit[i] = w_bcast | (32'(bus.A) == i);
        end
    end

    always_comb begin
        w_rdy = 1'b0;
        if (!rst_n) begin
            w_rdy = 1'b0;
        end else if (w_bcast) begin
            w_rdy = &w_free;
        end else if (!w_in_range) begin
            w_rdy = 1'b1;
        end else begin
            w_rdy = |(w_hit & w_free);
        end
    end

    assign w_xfer = bus.din_valid & w_rdy;
    assign w_load = {NCH{w_xfer}} & w_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dat <= '0;
            r_vld <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (w_load[i]) begin
                    r_dat[i] <= bus.din;
                    r_vld[i] <= 1'b1;
                end else if (bus.Y_ready[i]) begin
                    r_vld[i] <= 1'b0;
                end
            end
        end
    end

    // Out-of-range select only occurs when NCH is not a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop <= '0;
        end else if (w_xfer && !w_in_range && !w_bcast && r_drop != 8'hFF) begin
            r_drop <= r_drop + 8'd1;
        end
    end

    assign bus.din_ready = w_rdy;
    assign bus.Y         = r_dat;
    assign bus.Y_valid   = r_vld;
    assign drop_cnt      = r_drop;
endmodule

// File: tb/tb_demux_stream_1xn.sv
// Directed bench for demux_stream_1xn: NCH=4 instance for datapath/handshake, NCH=5 for drop counting.
module tb_demux_stream_1xn;
    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] drop0;
    logic [7:0] drop1;
    int         n_chk = 0;
    int         n_err = 0;

    demux_stream_1xn_if #(.DW(8), .NCH(4)) b0 ();
    demux_stream_1xn_if #(.DW(8), .NCH(5)) b1 ();

    demux_stream_1xn #(.DW(8), .NCH(4)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0), .drop_cnt(drop0));
    demux_stream_1xn #(.DW(8), .NCH(5)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1), .drop_cnt(drop1));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        b0.din = '0; b0.A = '0; b0.din_valid = 1'b0; b0.Y_ready = '0;
        b1.din = '0; b1.A = '0; b1.din_valid = 1'b0; b1.Y_ready = '0;
`ifdef DEMUX_BCAST_EN
        b0.bcast = 1'b0;
        b1.bcast = 1'b0;
`endif
        // Reset state, with a word offered to an empty lane so din_ready would otherwise be 1
        b0.din_valid = 1'b1;
        #2;
        chk("rst_yvalid", 64'(b0.Y_valid), 64'h0);
        chk("rst_y", 64'(b0.Y), 64'h0);
        chk("rst_drop", 64'(drop0), 64'h0);
        chk("rst_ready", 64'(b0.din_ready), 64'h0);
        b0.din_valid = 1'b0;
        #1 rst_n = 1'b1;
        step();

        // Single word to ch2, drained next cycle
        b0.Y_ready = 4'hF; b0.din = 8'hA5; b0.A = 2'd2; b0.din_valid = 1'b1;
        #1 chk("a5_ready", 64'(b0.din_ready), 64'h1);
        step();
        b0.din_valid = 1'b0;
        chk("a5_yvalid", 64'(b0.Y_valid), 64'h4);
        chk("a5_lane", 64'(b0.Y[23:16]), 64'hA5);
        step();
        chk("a5_drained", 64'(b0.Y_valid), 64'h0);
        chk("a5_data_hold", 64'(b0.Y[23:16]), 64'hA5);

        // Backpressure on ch1
        b0.Y_ready = 4'h0; b0.din = 8'h11; b0.A = 2'd1; b0.din_valid = 1'b1;
        step();
        b0.din = 8'h22;
        #1 chk("bp_ready0", 64'(b0.din_ready), 64'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_hold_lane", 64'(b0.Y[15:8]), 64'h11);
            chk("bp_hold_valid", 64'(b0.Y_valid), 64'h2);
        end
        b0.Y_ready = 4'b0010;
        #1 chk("bp_ready1", 64'(b0.din_ready), 64'h1);
        step();
        b0.din_valid = 1'b0;
        chk("bp_22_valid", 64'(b0.Y_valid), 64'h2);
        chk("bp_22_lane", 64'(b0.Y[15:8]), 64'h22);
        chk("bp_other_lane", 64'(b0.Y[23:16]), 64'hA5);
        step();
        chk("bp_drained", 64'(b0.Y_valid), 64'h0);

        // Back-to-back stream on ch3
        b0.Y_ready = 4'hF; b0.A = 2'd3;
        for (int k = 0; k < 16; k++) begin
            b0.din = 8'(8'h30 + k);
            b0.din_valid = 1'b1;
            #1 chk("strm_ready", 64'(b0.din_ready), 64'h1);
            step();
            chk("strm_lane", 64'(b0.Y[31:24]), 64'(8'h30 + k));
            chk("strm_valid", 64'(b0.Y_valid), 64'h8);
        end
        b0.din_valid = 1'b0;
        step();
        chk("strm_end", 64'(b0.Y_valid), 64'h0);

        // Independent lanes, simultaneous drain
        b0.Y_ready = 4'h0; b0.A = 2'd0; b0.din = 8'h0A; b0.din_valid = 1'b1;
        step();
        b0.A = 2'd2; b0.din = 8'h0C;
        step();
        b0.din_valid = 1'b0;
        chk("two_valid", 64'(b0.Y_valid), 64'h5);
        chk("two_bus", 64'(b0.Y), 64'h3F0C220A);
        b0.Y_ready = 4'b0101;
        step();
        chk("two_drain", 64'(b0.Y_valid), 64'h0);

        // Async reset with ch0/ch2 holding words
        b0.Y_ready = 4'h0; b0.A = 2'd0; b0.din = 8'hB0; b0.din_valid = 1'b1;
        step();
        b0.A = 2'd2; b0.din = 8'hB2;
        step();
        b0.din_valid = 1'b0;
        chk("pre_rst_valid", 64'(b0.Y_valid), 64'h5);
        #2 rst_n = 1'b0;
        b0.din_valid = 1'b1; b0.A = 2'd1; b0.din = 8'h77;
        #1;
        chk("arst_yvalid", 64'(b0.Y_valid), 64'h0);
        chk("arst_y", 64'(b0.Y), 64'h0);
        chk("arst_ready", 64'(b0.din_ready), 64'h0);
        #4 rst_n = 1'b1;
        step();
        b0.din_valid = 1'b0;
        chk("post_rst_valid", 64'(b0.Y_valid), 64'h2);
        chk("post_rst_lane", 64'(b0.Y[15:8]), 64'h77);

        // Same-cycle drain and refill on ch1
        b0.Y_ready = 4'b0010; b0.din = 8'h78; b0.din_valid = 1'b1;
        #1 chk("refill_ready", 64'(b0.din_ready), 64'h1);
        step();
        b0.din_valid = 1'b0;
        chk("refill_valid", 64'(b0.Y_valid), 64'h2);
        chk("refill_lane", 64'(b0.Y[15:8]), 64'h78);
        step();
        chk("refill_drain", 64'(b0.Y_valid), 64'h0);

`ifdef DEMUX_BCAST_EN
        b0.Y_ready = 4'h0; b0.A = 2'd1; b0.din = 8'hC1; b0.din_valid = 1'b1;
        step();
        b0.bcast = 1'b1; b0.din = 8'h5A;
        #1 chk("bc_ready0", 64'(b0.din_ready), 64'h0);
        b0.Y_ready = 4'b0010;
        #1 chk("bc_ready1", 64'(b0.din_ready), 64'h1);
        step();
        b0.din_valid = 1'b0; b0.bcast = 1'b0; b0.Y_ready = 4'h0;
        chk("bc_valid", 64'(b0.Y_valid), 64'hF);
        chk("bc_bus", 64'(b0.Y), 64'h5A5A5A5A);
        chk("bc_drop", 64'(drop0), 64'h0);
        b0.Y_ready = 4'hF;
        step();
`endif

        // NCH=5: top in-range lane, then out-of-range drops
        b1.Y_ready = 5'h1F; b1.A = 3'd4; b1.din = 8'h44; b1.din_valid = 1'b1;
        #1 chk("n5_ready_ch4", 64'(b1.din_ready), 64'h1);
        step();
        b1.din_valid = 1'b0;
        chk("n5_valid_ch4", 64'(b1.Y_valid), 64'h10);
        chk("n5_lane_ch4", 64'(b1.Y[39:32]), 64'h44);
        step();
        chk("n5_drain_ch4", 64'(b1.Y_valid), 64'h0);

        b1.Y_ready = 5'h0; b1.A = 3'd6; b1.din_valid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            b1.din = 8'(k);
            #1 chk("drop_ready", 64'(b1.din_ready), 64'h1);
            step();
            if (k == 9) chk("drop_cnt10", 64'(drop1), 64'd10);
        end
        b1.din_valid = 1'b0;
        chk("drop_sat", 64'(drop1), 64'd255);
        chk("drop_yvalid", 64'(b1.Y_valid), 64'h0);
        chk("drop_other_cnt", 64'(drop0), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
